// File: rtl/ecc_76_pkg.sv
// rtl/ecc_76_pkg.sv - shared encodings and classifier for the 76-bit ECC error monitor
package ecc_76_pkg;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SBIT  = 2'd1,
        ERR_DBIT  = 2'd2,
        ERR_FAULT = 2'd3
    } err_type_e;

    typedef enum logic {
        LOG_EMPTY = 1'b0,
        LOG_HELD  = 1'b1
    } log_state_e;

    // One class per beat; a checker fault outranks whatever the decoder reported.
    function automatic err_type_e classify(input logic vld, input logic sbit,
                                           input logic dbit, input logic fault);
        err_type_e cls;
        cls = ERR_NONE;
        if (vld) begin
            if (fault)
                cls = ERR_FAULT;
            else if (dbit)
                cls = ERR_DBIT;
            else if (sbit)
                cls = ERR_SBIT;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// rtl/ecc_sat_cnt.sv - saturating event counter with clear-then-increment semantics
module ecc_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= inc ? CNT_ONE : '0;
        else if (inc && (cnt != CNT_MAX))
            cnt <= cnt + CNT_ONE;
    end

endmodule

// File: rtl/ecc_76_err_monitor.sv
// rtl/ecc_76_err_monitor.sv - registers/poisons checked read data, counts and logs ECC events, raises irq
module ecc_76_err_monitor
    import ecc_76_pkg::*;
#(
    parameter int DATA_WIDTH = 76,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter bit POISON_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  clr,
    input  logic [2:0]            irq_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_vld,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic                  err_vld,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [1:0]            err_type,
    output logic                  irq
);

    err_type_e  cls;
    logic       is_sbit, is_dbit, is_fault, is_err;
    logic       poison;
    logic [2:0] sticky, sticky_nxt;
    log_state_e state, state_nxt;
    logic       log_capture;

    assign cls      = classify(rd_vld, sbit_err, dbit_err, ecc_fault);
    assign is_sbit  = (cls == ERR_SBIT);
    assign is_dbit  = (cls == ERR_DBIT);
    assign is_fault = (cls == ERR_FAULT);
    assign is_err   = (cls != ERR_NONE);
    assign poison   = POISON_EN && rd_vld && (dbit_err || ecc_fault);

    // Data path is untouched by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            data_vld <= 1'b0;
        end else begin
            data_out <= poison ? {DATA_WIDTH{1'b1}} : data_in;
            data_vld <= rd_vld;
        end
    end

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
        .clk(clk), .rst_n(rst_n), .inc(is_sbit), .clr(clr), .cnt(sbit_cnt)
    );

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
        .clk(clk), .rst_n(rst_n), .inc(is_dbit), .clr(clr), .cnt(dbit_cnt)
    );

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk(clk), .rst_n(rst_n), .inc(is_fault), .clr(clr), .cnt(fault_cnt)
    );

    // irq is taken from the next sticky value so it rises with the counters.
    assign sticky_nxt = (clr ? 3'b000 : sticky) | {is_fault, is_dbit, is_sbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 3'b000;
            irq    <= 1'b0;
        end else begin
            sticky <= sticky_nxt;
            irq    <= |(sticky_nxt & irq_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOG_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOG_EMPTY: if (is_err) state_nxt = LOG_HELD;
            LOG_HELD:  if (clr && !is_err) state_nxt = LOG_EMPTY;
            default:   state_nxt = LOG_EMPTY;
        endcase
    end

    // A clear in HELD reopens the log, so a same-cycle error is captured again.
    always_comb begin
        err_vld     = (state == LOG_HELD);
        log_capture = is_err && ((state == LOG_EMPTY) || clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_type <= ERR_NONE;
        end else if (log_capture) begin
            err_addr <= rd_addr;
            err_type <= cls;
        end else if (clr) begin
            err_addr <= '0;
            err_type <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_ecc_76_err_monitor.sv
// tb/tb_ecc_76_err_monitor.sv - directed self-checking bench for ecc_76_err_monitor
module tb_ecc_76_err_monitor;
    import ecc_76_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_vld;
    logic [7:0]  rd_addr;
    logic [75:0] data_in;
    logic        sbit_err, dbit_err, ecc_fault, clr;
    logic [2:0]  irq_en;

    logic [75:0] data_out;
    logic        data_vld, err_vld, irq;
    logic [15:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic [7:0]  err_addr;
    logic [1:0]  err_type;

    logic [75:0] s_data_out;
    logic        s_data_vld, s_err_vld, s_irq;
    logic [3:0]  s_sbit_cnt, s_dbit_cnt, s_fault_cnt;
    logic [7:0]  s_err_addr;
    logic [1:0]  s_err_type;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [75:0] ALL_ONES = {76{1'b1}};

    always #5 clk = ~clk;

    ecc_76_err_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_addr(rd_addr), .data_in(data_in),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault), .clr(clr),
        .irq_en(irq_en), .data_out(data_out), .data_vld(data_vld), .sbit_cnt(sbit_cnt),
        .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .err_vld(err_vld), .err_addr(err_addr),
        .err_type(err_type), .irq(irq)
    );

    ecc_76_err_monitor #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_addr(rd_addr), .data_in(data_in),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault), .clr(clr),
        .irq_en(irq_en), .data_out(s_data_out), .data_vld(s_data_vld), .sbit_cnt(s_sbit_cnt),
        .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt), .err_vld(s_err_vld), .err_addr(s_err_addr),
        .err_type(s_err_type), .irq(s_irq)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic idle_inputs();
        rd_vld = 1'b0; rd_addr = 8'h00; data_in = '0;
        sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0; clr = 1'b0;
    endtask

    // Apply one cycle of stimulus, then sample #1 after the edge that registers it.
    task automatic beat(input logic v, input logic [7:0] a, input logic [75:0] d,
                        input logic s, input logic db, input logic f, input logic c);
        rd_vld = v; rd_addr = a; data_in = d;
        sbit_err = s; dbit_err = db; ecc_fault = f; clr = c;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        irq_en = 3'b000;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_vld", data_vld, 0);
        check("rst_err_vld", err_vld, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        // clean read
        beat(1, 8'h10, 76'h123, 0, 0, 0, 0);
        check("clean_vld", data_vld, 1);
        check("clean_data", data_out, 76'h123);
        check("clean_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        check("clean_err_vld", err_vld, 0);

        // sbit then dbit, only dbit interrupt enabled
        irq_en = 3'b010;
        beat(1, 8'h05, 76'hABC, 1, 0, 0, 0);
        check("sb_cnt", sbit_cnt, 1);
        check("sb_data", data_out, 76'hABC);
        check("sb_err_vld", err_vld, 1);
        check("sb_err_addr", err_addr, 8'h05);
        check("sb_err_type", err_type, ERR_SBIT);
        check("sb_irq", irq, 0);
        beat(1, 8'h06, 76'h456, 0, 1, 0, 0);
        check("db_cnt", dbit_cnt, 1);
        check("db_sbit_cnt", sbit_cnt, 1);
        check("db_poison", data_out, ALL_ONES);
        check("db_err_addr", err_addr, 8'h05);
        check("db_err_type", err_type, ERR_SBIT);
        check("db_irq", irq, 1);

        // clear, then errors without rd_vld are ignored
        beat(0, 8'h00, 76'h0, 0, 0, 0, 1);
        check("clr_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        check("clr_err_vld", err_vld, 0);
        check("clr_irq", irq, 0);
        beat(0, 8'h09, 76'h777, 1, 0, 0, 0);
        check("novld_cnt", sbit_cnt, 0);
        check("novld_err_vld", err_vld, 0);
        check("novld_data_vld", data_vld, 0);

        // fault and dbit together count as fault only
        beat(1, 8'h22, 76'h999, 0, 1, 1, 0);
        check("flt_cnt", fault_cnt, 1);
        check("flt_dbit_cnt", dbit_cnt, 0);
        check("flt_type", err_type, ERR_FAULT);
        check("flt_addr", err_addr, 8'h22);
        check("flt_poison", data_out, ALL_ONES);
        check("flt_irq_masked", irq, 0);
        irq_en = 3'b100;
        beat(0, 8'h00, 76'h0, 0, 0, 0, 0);
        check("flt_irq_en", irq, 1);

        // saturation on the 4-bit instance
        beat(0, 8'h00, 76'h0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            beat(1, 8'(i + 8'h40), 76'h1, 1, 0, 0, 0);
        check("sat_cnt4", s_sbit_cnt, 4'hF);
        check("sat_cnt16", sbit_cnt, 16'd20);
        check("sat_first_addr", err_addr, 8'h40);
        beat(1, 8'h60, 76'h1, 1, 0, 0, 0);
        check("sat_hold", s_sbit_cnt, 4'hF);
        beat(0, 8'h00, 76'h0, 0, 0, 0, 1);
        check("sat_clr", s_sbit_cnt, 0);
        check("sat_clr_err_vld", s_err_vld, 0);
        beat(1, 8'h33, 76'h5, 1, 0, 0, 1);
        check("clrbeat_cnt", s_sbit_cnt, 1);
        check("clrbeat_err_vld", s_err_vld, 1);
        check("clrbeat_addr", s_err_addr, 8'h33);
        check("clrbeat_data", s_data_out, 76'h5);

        // clr plus beat while log is held re-captures
        beat(1, 8'h44, 76'h6, 0, 1, 0, 1);
        check("reheld_addr", err_addr, 8'h44);
        check("reheld_type", err_type, ERR_DBIT);
        check("reheld_vld", err_vld, 1);
        check("reheld_dbit", dbit_cnt, 1);
        check("reheld_sbit", sbit_cnt, 0);

        // reset mid-burst
        rd_vld = 1; rd_addr = 8'h50; data_in = 76'h321; sbit_err = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_data_vld", data_vld, 0);
        check("mrst_data_out", data_out, 0);
        check("mrst_cnt", sbit_cnt, 0);
        check("mrst_err_vld", err_vld, 0);
        check("mrst_irq", irq, 0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_irq", irq, 0);
        beat(1, 8'h07, 76'h8, 1, 0, 0, 0);
        check("post_rst_cnt", sbit_cnt, 1);
        check("post_rst_addr", err_addr, 8'h07);
        check("post_rst_type", err_type, ERR_SBIT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
